// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared types and helpers for the instruction loader
package inst_loader_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    // A program must hold at least one instruction and fit in instruction memory.
    function automatic logic len_legal(input logic [BYTE_WIDTH-1:0] n, input int mem_number);
        return (n != '0) && (32'(n) <= mem_number);
    endfunction

endpackage

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - byte-stream program loader feeding the CPU instruction-memory write port
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ISA_WIDTH      = 16,
    parameter int MEM_ADDR_WIDTH = 5,
    parameter int MEM_NUMBER     = 32
) (
    input  logic                      Clk_i,
    input  logic                      Rst_i,
    input  logic                      Start_i,
    input  logic                      Byte_valid_i,
    input  logic [BYTE_WIDTH-1:0]     Byte_data_i,
    output logic                      Byte_ready_o,
    output logic                      Inst_wen_o,
    output logic [MEM_ADDR_WIDTH-1:0] Inst_addr_o,
    output logic [ISA_WIDTH-1:0]      Input_inst_o,
    output logic                      Cpu_rst_n_o,
    output logic                      Done_o,
    output logic                      Err_o
);

    state_t                  state;
    logic [BYTE_WIDTH-1:0]   len;
    logic [BYTE_WIDTH-1:0]   hi_byte;
    logic [BYTE_WIDTH-1:0]   xor_acc;
    logic [MEM_ADDR_WIDTH-1:0] idx;
    logic                    accept;
    logic                    idx_last;

    assign accept   = Byte_valid_i && Byte_ready_o;
    assign idx_last = ({{(BYTE_WIDTH-MEM_ADDR_WIDTH){1'b0}}, idx} == (len - 8'd1));

    // Byte_ready_o is registered alongside the state so it is high exactly in LEN/HI/LO/CHK.
    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            state        <= IDLE;
            len          <= '0;
            hi_byte      <= '0;
            xor_acc      <= '0;
            idx          <= '0;
            Byte_ready_o <= 1'b0;
            Inst_wen_o   <= 1'b0;
            Inst_addr_o  <= '0;
            Input_inst_o <= '0;
            Cpu_rst_n_o  <= 1'b0;
            Done_o       <= 1'b0;
            Err_o        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (Start_i) begin
                        state        <= LEN;
                        Byte_ready_o <= 1'b1;
                        Done_o       <= 1'b0;
                        Err_o        <= 1'b0;
                        Cpu_rst_n_o  <= 1'b0;
                    end
                end
                LEN: begin
                    if (accept) begin
                        len <= Byte_data_i;
                        if (len_legal(Byte_data_i, MEM_NUMBER)) begin
                            idx     <= '0;
                            xor_acc <= '0;
                            state   <= HI;
                        end else begin
                            state        <= ERR;
                            Byte_ready_o <= 1'b0;
                            Err_o        <= 1'b1;
                            Cpu_rst_n_o  <= 1'b0;
                        end
                    end
                end
                HI: begin
                    if (accept) begin
                        hi_byte <= Byte_data_i;
                        xor_acc <= xor_acc ^ Byte_data_i;
                        state   <= LO;
                    end
                end
                LO: begin
                    if (accept) begin
                        Input_inst_o <= {hi_byte, Byte_data_i};
                        Inst_addr_o  <= idx;
                        xor_acc      <= xor_acc ^ Byte_data_i;
                        Inst_wen_o   <= 1'b1;
                        Byte_ready_o <= 1'b0;
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    Inst_wen_o   <= 1'b0;
                    Byte_ready_o <= 1'b1;
                    if (idx_last) begin
                        state <= CHK;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= HI;
                    end
                end
                CHK: begin
                    if (accept) begin
                        Byte_ready_o <= 1'b0;
                        if (Byte_data_i == xor_acc) begin
                            state       <= DONE;
                            Done_o      <= 1'b1;
                            Cpu_rst_n_o <= 1'b1;
                        end else begin
                            state       <= ERR;
                            Err_o       <= 1'b1;
                            Cpu_rst_n_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    Byte_ready_o <= 1'b0;
                    Inst_wen_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - scoreboard bench for inst_loader with randomized program loads
module tb_inst_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        inst_wen;
    logic [4:0]  inst_addr;
    logic [15:0] input_inst;
    logic        cpu_rst_n;
    logic        done;
    logic        err;

    inst_loader dut (
        .Clk_i        (clk),
        .Rst_i        (rst),
        .Start_i      (start),
        .Byte_valid_i (byte_valid),
        .Byte_data_i  (byte_data),
        .Byte_ready_o (byte_ready),
        .Inst_wen_o   (inst_wen),
        .Inst_addr_o  (inst_addr),
        .Input_inst_o (input_inst),
        .Cpu_rst_n_o  (cpu_rst_n),
        .Done_o       (done),
        .Err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 write, 1 done, 2 err
        logic [4:0]  addr;
        logic [15:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] prog[32];
    logic        prev_wen  = 1'b0;
    logic        prev_done = 1'b0;
    logic        prev_err  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int kind, input logic [4:0] addr, input logic [15:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input logic [4:0] addr, input logic [15:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (e.kind == 0 && kind == 0) begin
                chk("write_addr", 32'(addr), 32'(e.addr));
                chk("write_data", 32'(data), 32'(e.data));
            end
        end
    endtask

    // Monitor: every observable write/done/err edge is matched against the scoreboard.
    always @(negedge clk) begin
        if (inst_wen) begin
            chk("wen_single_cycle", 32'(prev_wen), 32'd0);
            pop_check(0, inst_addr, input_inst);
        end
        if (done && !prev_done) pop_check(1, 5'd0, 16'd0);
        if (err && !prev_err) pop_check(2, 5'd0, 16'd0);
        if (done || err) chk("cpu_rst_n_vs_done", 32'(cpu_rst_n), 32'(done));
        prev_wen  = inst_wen;
        prev_done = done;
        prev_err  = err;
    end

    task automatic idle_gap(input int gap_max, input bit noise);
        int g;
        g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
        repeat (g) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            start      = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max, input bit noise);
        int cnt;
        idle_gap(gap_max, noise);
        byte_valid = 1'b1;
        byte_data  = b;
        cnt = 0;
        while (!byte_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) chk("byte_ready_timeout", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_clears_done", 32'(done), 32'd0);
        chk("start_clears_err", 32'(err), 32'd0);
        chk("start_holds_cpu", 32'(cpu_rst_n), 32'd0);
    endtask

    // Model: length byte, 2N bytes high-first, XOR checksum; illegal N errors immediately.
    task automatic load(input logic [7:0] n, input bit bad_chk, input int gap_max, input bit noise);
        logic [7:0] x;
        pulse_start();
        send_byte(n, gap_max, 1'b0);
        if (n == 0 || n > 32) begin
            push_ev(2, 5'd0, 16'd0);
            chk("bad_len_err", 32'(err), 32'd1);
            chk("bad_len_ready", 32'(byte_ready), 32'd0);
        end else begin
            x = 8'h00;
            for (int i = 0; i < int'(n); i++) begin
                send_byte(prog[i][15:8], gap_max, noise);
                send_byte(prog[i][7:0], gap_max, noise);
                x = x ^ prog[i][15:8] ^ prog[i][7:0];
                push_ev(0, 5'(i), prog[i]);
                @(negedge clk);
                chk("wen_after_lo", 32'(inst_wen), 32'd1);
            end
            send_byte(bad_chk ? (x ^ 8'h01) : x, gap_max, noise);
            push_ev(bad_chk ? 2 : 1, 5'd0, 16'd0);
            chk("end_done", 32'(done), bad_chk ? 32'd0 : 32'd1);
            chk("end_err", 32'(err), bad_chk ? 32'd1 : 32'd0);
            chk("end_cpu_rst_n", 32'(cpu_rst_n), bad_chk ? 32'd0 : 32'd1);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_wen"}, 32'(inst_wen), 32'd0);
        chk({tag, "_addr"}, 32'(inst_addr), 32'd0);
        chk({tag, "_inst"}, 32'(input_inst), 32'd0);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic randomize_prog();
        for (int i = 0; i < 32; i++) prog[i] = 16'($urandom);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("in_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("idle");

        prog[0] = 16'h1234;
        prog[1] = 16'hABCD;
        load(8'h02, 1'b0, 0, 1'b0);
        load(8'h02, 1'b1, 0, 1'b0);
        load(8'h00, 1'b0, 0, 1'b0);
        load(8'h21, 1'b0, 0, 1'b0);

        randomize_prog();
        load(8'h20, 1'b0, 3, 1'b1);

        // Reset right after the low byte of the first instruction: its write must not appear.
        randomize_prog();
        pulse_start();
        send_byte(8'h02, 0, 1'b0);
        send_byte(prog[0][15:8], 0, 1'b0);
        send_byte(prog[0][7:0], 0, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_values("mid_load_reset");
        repeat (3) @(negedge clk);
        chk("reset_no_wen", 32'(inst_wen), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        load(8'h02, 1'b0, 1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            randomize_prog();
            load(8'($urandom_range(36, 0)), 1'($urandom_range(1, 0)), 2, 1'b1);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Program loader sitting directly upstream of the single-cycle CPU's instruction-memory write port.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instructions from it.
- Writes each instruction into instruction memory through the CPU's Inst_wen_i / Input_inst_i path.
- Holds the CPU in reset until a complete, checksum-verified program has been loaded.

Parameters:
ISA_WIDTH, 16, instruction width; fixed at two bytes.
MEM_ADDR_WIDTH, 5, instruction memory address width.
MEM_NUMBER, 32, instruction memory depth; largest legal program length.

Ports:
Clk_i  in  1  single clock; all state changes on the rising edge.
Rst_i  in  1  asynchronous active-high reset.
Start_i  in  1  begin a load; honoured only in IDLE, DONE or ERR.
Byte_valid_i  in  1  source has a byte on Byte_data_i.
Byte_data_i  in  8  stream byte.
Byte_ready_o  out  1  loader accepts a byte this cycle.
Inst_wen_o  out  1  instruction-memory write strobe; drives CPU Inst_wen_i.
Inst_addr_o  out  MEM_ADDR_WIDTH  write address.
Input_inst_o  out  ISA_WIDTH  write data; drives CPU Input_inst_i.
Cpu_rst_n_o  out  1  active-low reset to the CPU; low holds the CPU.
Done_o  out  1  load completed and checksum matched.
Err_o  out  1  load aborted because of a bad length or checksum.

Behaviour:
- Handshake: a byte is accepted on a rising edge where Byte_valid_i && Byte_ready_o.
  - Byte_ready_o is high only in LEN, HI, LO and CHK.
  - Byte_ready_o does not depend on Byte_valid_i.
- Stream format: length byte N, then 2N instruction bytes (high byte first), then one checksum byte.
  - The checksum is the XOR of all 2N instruction bytes.
- Reset values: state IDLE, Byte_ready_o=0, Inst_wen_o=0, Inst_addr_o=0, Input_inst_o=0, Cpu_rst_n_o=0, Done_o=0, Err_o=0; internal idx=0, len=0, xor_acc=0.
- FSM states and transitions:
  - IDLE: Start_i -> LEN.
  - LEN: on accept, latch N.
    - N==0 or N>MEM_NUMBER -> ERR.
    - Otherwise idx=0, xor_acc=0 -> HI.
  - HI: on accept, hold the byte as the upper half, xor_acc^=byte -> LO.
  - LO: on accept, form Input_inst_o={hi,byte}, Inst_addr_o=idx, xor_acc^=byte -> WRITE.
  - WRITE: lasts exactly one cycle with Inst_wen_o=1.
    - idx==N-1 -> CHK.
    - Otherwise idx++ -> HI.
  - CHK: on accept, byte==xor_acc -> DONE, else -> ERR.
  - DONE: Done_o=1, Cpu_rst_n_o=1. Start_i -> LEN.
  - ERR: Err_o=1, Cpu_rst_n_o=0. Start_i -> LEN.
- Start_i semantics:
  - Entering LEN from DONE or ERR clears Done_o and Err_o and drives Cpu_rst_n_o=0 in the same edge.
  - Start_i in LEN, HI, LO, WRITE or CHK is ignored.
- Timing:
  - Inst_wen_o rises the cycle after the low byte is accepted.
  - Inst_addr_o and Input_inst_o are stable while Inst_wen_o is high and hold their values afterwards.
  - Done_o and Cpu_rst_n_o rise the cycle after a matching checksum byte is accepted.
  - Minimum load time with no stall is 1+3N+1 accepting/write cycles after Start_i.
- Stalls: Byte_valid_i gaps stall in place; no timeout.
- Address range: idx never exceeds MEM_NUMBER-1, so there is no address wrap.
- Reset mid-load: asynchronous return to reset values; the partially written memory is left as is; the CPU stays held.
- Inst_wen_o is never high outside WRITE.

Decomposition:
- Package inst_loader_pkg holds:
  - the state enum (IDLE, LEN, HI, LO, WRITE, CHK, DONE, ERR);
  - the byte width constant (8);
  - a length-legality function taking N and MEM_NUMBER.
- Single module; no sub-module. The XOR accumulator and byte pair register are inline.

Test Plan:
- Rst_i pulse, then idle -> all outputs at reset values; Cpu_rst_n_o=0; Byte_ready_o=0.
- Start_i; stream 02,12,34,AB,CD,40 with no gaps:
  - writes addr0=0x1234 and addr1=0xABCD, each as a one-cycle Inst_wen_o;
  - Done_o=1 and Cpu_rst_n_o=1 one cycle after the 0x40 byte.
- Same stream with checksum 0x41 -> both writes occur, then Err_o=1, Done_o=0, Cpu_rst_n_o=0.
- Length byte 0x00 -> ERR with no writes; after a second Start_i, length 0x21 -> ERR with no writes.
- Length 0x20 with 64 bytes, random Byte_valid_i gaps and Start_i pulses mid-load:
  - 32 writes at addresses 0..31, in order, with correct data;
  - the Start_i pulses are ignored;
  - Done_o=1 at the end.
- Assert Rst_i after the 3rd byte of a 2-instruction load:
  - immediate reset values and no further Inst_wen_o;
  - a subsequent full load completes with Done_o=1.
